// File: rtl/string_rep_engine.sv
// REP string-iteration engine: issues one STOS/MOVS/CMPS/SCAS element per memory handshake,
// checks each element against the ES limit/rights and stops on COUNT, ZF, INTR or IGNORED.
module string_rep_engine #(
    parameter int YIELD_CNT = 16,
    parameter bit SIZE8_EN  = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  cfg_size,
    input  logic        cfg_addr16,
    input  logic [1:0]  cfg_rep,
    input  logic        cfg_zf_cond,
    input  logic        cfg_dflag,
    input  logic        cfg_fault_check,
    input  logic [31:0] ecx_in,
    input  logic [31:0] esi_in,
    input  logic [31:0] edi_in,
    input  logic [31:0] es_base,
    input  logic [31:0] es_limit,
    input  logic [63:0] es_cache,
    input  logic        es_cache_valid,
    input  logic        irq_pending,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_len,
    input  logic        mem_ack,
    input  logic        mem_zf,
    output logic        busy,
    output logic        done,
    output logic [1:0]  done_reason,
    output logic        fault,
    output logic [31:0] esi_out,
    output logic [31:0] edi_out,
    output logic [31:0] ecx_out,
    output logic [2:0]  state_dbg
);
    // Memory handshake: mem_req rises when an element is issued and holds mem_addr/mem_len
    // steady; the element completes in the first cycle with mem_req && mem_ack, and mem_req
    // falls on the following cycle. mem_ack without an outstanding mem_req has no effect.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_ISSUE  = 3'd2,
        S_UPDATE = 3'd3,
        S_FIN    = 3'd4,
        S_FLT    = 3'd5
    } state_t;

    localparam logic [1:0] R_COUNT   = 2'd0;
    localparam logic [1:0] R_ZF      = 2'd1;
    localparam logic [1:0] R_INTR    = 2'd2;
    localparam logic [1:0] R_IGNORED = 2'd3;
    localparam int YW = $clog2(YIELD_CNT + 1);
    localparam logic [YW-1:0] YIELD_LAST = YW'(YIELD_CNT);

    state_t state, state_next;

    logic [3:0]    len_q;
    logic          addr16_q;
    logic [1:0]    rep_q;
    logic          zf_cond_q;
    logic          dflag_q;
    logic          fchk_q;
    logic          zf_q;
    logic [1:0]    reason_q;
    logic [1:0]    term_reason;
    logic [YW-1:0] yield_cnt;
    logic [YW-1:0] yield_next;
    logic [31:0]   offset;
    logic [31:0]   upper;
    logic [31:0]   len_m1;
    logic          seg_fault;
    logic          start_skip;
    logic          count_is_one;
    logic          zf_hit;
    logic          yield_hit;
    logic          unused_es_bits;

    function automatic logic [3:0] size_to_len(input logic [1:0] size);
        logic [3:0] len;
        case (size)
            2'd0:    len = 4'd1;
            2'd1:    len = 4'd2;
            2'd2:    len = 4'd4;
            default: len = SIZE8_EN ? 4'd8 : 4'd4;
        endcase
        return len;
    endfunction

    // In 16-bit mode only the low word moves and wraps; the high word is carried through.
    function automatic logic [31:0] step_ptr(input logic [31:0] p, input logic [3:0] len,
                                             input logic dec, input logic a16);
        logic [31:0] full;
        logic [15:0] low;
        full = dec ? (p - {28'h0, len}) : (p + {28'h0, len});
        low  = dec ? (p[15:0] - {12'h0, len}) : (p[15:0] + {12'h0, len});
        return a16 ? {p[31:16], low} : full;
    endfunction

    assign state_dbg      = state;
    assign unused_es_bits = ^{es_cache[63:55], es_cache[53:44], es_cache[40:0]};

    assign start_skip = (cfg_rep != 2'd0) &&
                        (cfg_addr16 ? (ecx_in[15:0] == 16'd0) : (ecx_in == 32'd0));

    assign offset       = addr16_q ? {16'h0, edi_out[15:0]} : edi_out;
    assign upper        = es_cache[54] ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    assign len_m1       = {28'h0, len_q} - 32'd1;
    assign count_is_one = addr16_q ? (ecx_out[15:0] == 16'd1) : (ecx_out == 32'd1);
    assign zf_hit       = zf_cond_q && (((rep_q == 2'd1) && zf_q) || ((rep_q == 2'd2) && !zf_q));
    assign yield_next   = yield_cnt + YW'(1);
    assign yield_hit    = (yield_next == YIELD_LAST);

    always_comb begin
        seg_fault = 1'b0;
        if (fchk_q) begin
            if (!es_cache_valid || es_cache[43] || !es_cache[41]) begin
                seg_fault = 1'b1;
            end else if (es_cache[42]) begin
                // Expand-down: valid offsets lie strictly above the limit, up to upper.
                seg_fault = (offset <= es_limit) || (offset > upper) || ((upper - offset) < len_m1);
            end else begin
                seg_fault = (offset > es_limit) || ((es_limit - offset) < len_m1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        term_reason = R_COUNT;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = start_skip ? S_FIN : S_CHECK;
                end
            end
            S_CHECK: begin
                state_next = seg_fault ? S_FLT : S_ISSUE;
            end
            S_ISSUE: begin
                if (mem_req && mem_ack) begin
                    state_next = S_UPDATE;
                end
            end
            S_UPDATE: begin
                // Priority order: count, ZF condition, interrupt/yield.
                if ((rep_q == 2'd0) || count_is_one) begin
                    state_next  = S_FIN;
                    term_reason = R_COUNT;
                end else if (zf_hit) begin
                    state_next  = S_FIN;
                    term_reason = R_ZF;
                end else if (irq_pending || yield_hit) begin
                    state_next  = S_FIN;
                    term_reason = R_INTR;
                end else begin
                    state_next = S_CHECK;
                end
            end
            S_FIN:   state_next = S_IDLE;
            S_FLT:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req     <= 1'b0;
            mem_addr    <= 32'h0;
            mem_len     <= 4'h0;
            busy        <= 1'b0;
            done        <= 1'b0;
            done_reason <= R_COUNT;
            fault       <= 1'b0;
            esi_out     <= 32'h0;
            edi_out     <= 32'h0;
            ecx_out     <= 32'h0;
            len_q       <= 4'h0;
            addr16_q    <= 1'b0;
            rep_q       <= 2'd0;
            zf_cond_q   <= 1'b0;
            dflag_q     <= 1'b0;
            fchk_q      <= 1'b0;
            zf_q        <= 1'b0;
            reason_q    <= R_COUNT;
            yield_cnt   <= '0;
        end else begin
            done  <= 1'b0;
            fault <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        busy      <= 1'b1;
                        len_q     <= size_to_len(cfg_size);
                        addr16_q  <= cfg_addr16;
                        rep_q     <= cfg_rep;
                        zf_cond_q <= cfg_zf_cond;
                        dflag_q   <= cfg_dflag;
                        fchk_q    <= cfg_fault_check;
                        esi_out   <= esi_in;
                        edi_out   <= edi_in;
                        ecx_out   <= ecx_in;
                        if (start_skip) begin
                            reason_q <= R_IGNORED;
                        end
                    end
                end
                S_CHECK: begin
                    if (!seg_fault) begin
                        mem_req  <= 1'b1;
                        mem_addr <= es_base + offset;
                        mem_len  <= len_q;
                    end
                end
                S_ISSUE: begin
                    if (mem_req && mem_ack) begin
                        mem_req <= 1'b0;
                        zf_q    <= mem_zf;
                    end
                end
                S_UPDATE: begin
                    esi_out   <= step_ptr(esi_out, len_q, dflag_q, addr16_q);
                    edi_out   <= step_ptr(edi_out, len_q, dflag_q, addr16_q);
                    ecx_out   <= addr16_q ? {ecx_out[31:16], ecx_out[15:0] - 16'd1}
                                          : (ecx_out - 32'd1);
                    yield_cnt <= yield_next;
                    if (state_next == S_FIN) begin
                        reason_q <= term_reason;
                    end
                end
                S_FIN: begin
                    done        <= 1'b1;
                    done_reason <= reason_q;
                    busy        <= 1'b0;
                    yield_cnt   <= '0;
                end
                S_FLT: begin
                    fault     <= 1'b1;
                    busy      <= 1'b0;
                    yield_cnt <= '0;
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_string_rep_engine.sv
// Bench for string_rep_engine: directed and randomised REP runs checked against an
// element-by-element reference model of the string instruction semantics.
`timescale 1ns/1ps
module tb_string_rep_engine;
    localparam int YIELD = 16;
    localparam bit SIZE8 = 1'b1;
    localparam logic [63:0] ES_OK = (64'h1 << 54) | (64'h1 << 41);

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  cfg_size;
    logic        cfg_addr16;
    logic [1:0]  cfg_rep;
    logic        cfg_zf_cond;
    logic        cfg_dflag;
    logic        cfg_fault_check;
    logic [31:0] ecx_in, esi_in, edi_in;
    logic [31:0] es_base, es_limit;
    logic [63:0] es_cache;
    logic        es_cache_valid;
    logic        irq_pending;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [3:0]  mem_len;
    logic        mem_ack;
    logic        mem_zf;
    logic        busy, done, fault;
    logic [1:0]  done_reason;
    logic [31:0] esi_out, edi_out, ecx_out;
    logic [2:0]  state_dbg;

    always #5 clk = ~clk;

    string_rep_engine #(.YIELD_CNT(YIELD), .SIZE8_EN(SIZE8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_size(cfg_size), .cfg_addr16(cfg_addr16), .cfg_rep(cfg_rep),
        .cfg_zf_cond(cfg_zf_cond), .cfg_dflag(cfg_dflag), .cfg_fault_check(cfg_fault_check),
        .ecx_in(ecx_in), .esi_in(esi_in), .edi_in(edi_in),
        .es_base(es_base), .es_limit(es_limit), .es_cache(es_cache),
        .es_cache_valid(es_cache_valid), .irq_pending(irq_pending),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_len(mem_len),
        .mem_ack(mem_ack), .mem_zf(mem_zf),
        .busy(busy), .done(done), .done_reason(done_reason), .fault(fault),
        .esi_out(esi_out), .edi_out(edi_out), .ecx_out(ecx_out), .state_dbg(state_dbg)
    );

    int tests_run = 0;
    int tests_failed = 0;

    // Reference-model results: {linear address, length} per element, plus the outcome.
    logic [35:0] exp_q[$];
    logic [35:0] obs_q[$];
    int          exp_kind;
    logic [1:0]  exp_reason;
    logic [31:0] exp_esi, exp_edi, exp_ecx;
    bit          zf_seq[64];
    int          irq_at;

    bit          obs_done, obs_fault, obs_busy, obs_timeout, obs_unstable, obs_extra;
    logic [1:0]  obs_reason;
    logic [31:0] obs_esi, obs_edi, obs_ecx;
    int          obs_cycles;

    task automatic set_defaults();
        start = 0; mem_ack = 0; mem_zf = 0; irq_pending = 0;
        cfg_size = 0; cfg_addr16 = 0; cfg_rep = 2; cfg_zf_cond = 0; cfg_dflag = 0;
        cfg_fault_check = 1; ecx_in = 0; esi_in = 32'h400; edi_in = 0;
        es_base = 32'h1000; es_limit = 32'hFFFF; es_cache = ES_OK; es_cache_valid = 1;
        irq_at = 1000;
        for (int i = 0; i < 64; i++) zf_seq[i] = 1'b1;
    endtask

    task automatic model_run();
        logic [31:0] esi, edi, ecx, off, upper, cnt;
        logic [63:0] last_byte;
        int len;
        bit flt, stop;
        exp_q.delete(); exp_kind = 0; exp_reason = 2'd0;
        esi = esi_in; edi = edi_in; ecx = ecx_in;
        len = (cfg_size == 0) ? 1 : (cfg_size == 1) ? 2 : (cfg_size == 2) ? 4 : (SIZE8 ? 8 : 4);
        cnt = cfg_addr16 ? {16'h0, ecx[15:0]} : ecx;
        stop = 0;
        if (cfg_rep != 0 && cnt == 0) begin
            exp_reason = 2'd3; stop = 1;
        end
        for (int i = 1; i <= 40 && !stop; i++) begin
            off = cfg_addr16 ? {16'h0, edi[15:0]} : edi;
            last_byte = {32'h0, off} + 64'(len - 1);
            flt = 0;
            if (cfg_fault_check) begin
                if (!es_cache_valid || es_cache[43] || !es_cache[41]) flt = 1;
                else if (es_cache[42]) begin
                    upper = es_cache[54] ? 32'hFFFF_FFFF : 32'h0000_FFFF;
                    flt = (off <= es_limit) || (last_byte > {32'h0, upper});
                end else flt = (last_byte > {32'h0, es_limit});
            end
            if (flt) begin
                exp_kind = 1; stop = 1;
            end else begin
                exp_q.push_back({es_base + off, 4'(len)});
                cnt = cfg_addr16 ? {16'h0, ecx[15:0]} : ecx;
                if (cfg_addr16) begin
                    esi[15:0] = cfg_dflag ? esi[15:0] - 16'(len) : esi[15:0] + 16'(len);
                    edi[15:0] = cfg_dflag ? edi[15:0] - 16'(len) : edi[15:0] + 16'(len);
                    ecx[15:0] = ecx[15:0] - 16'd1;
                end else begin
                    esi = cfg_dflag ? esi - 32'(len) : esi + 32'(len);
                    edi = cfg_dflag ? edi - 32'(len) : edi + 32'(len);
                    ecx = ecx - 32'd1;
                end
                if (cfg_rep == 0 || cnt == 1) begin
                    exp_reason = 2'd0; stop = 1;
                end else if (cfg_zf_cond && ((cfg_rep == 1 && zf_seq[i-1]) || (cfg_rep == 2 && !zf_seq[i-1]))) begin
                    exp_reason = 2'd1; stop = 1;
                end else if (i >= irq_at || i == YIELD) begin
                    exp_reason = 2'd2; stop = 1;
                end
            end
        end
        exp_esi = esi; exp_edi = edi; exp_ecx = ecx;
    endtask

    // Driver: pulses start, plays a random-latency memory, records accesses and the outcome.
    task automatic run_op();
        int lat, n_acc;
        bit fin, seen;
        logic [35:0] seen_addr;
        obs_q.delete(); obs_done = 0; obs_fault = 0; obs_unstable = 0; obs_busy = 1;
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        lat = $urandom_range(0, 3); fin = 0; seen = 0; n_acc = 0; obs_cycles = 1;
        while (!fin && obs_cycles < 3000) begin
            mem_ack = 0;
            if (done || fault) begin
                fin = 1; obs_done = done; obs_fault = fault; obs_reason = done_reason;
                obs_busy = busy; obs_esi = esi_out; obs_edi = edi_out; obs_ecx = ecx_out;
            end else if (mem_req) begin
                if (!seen) begin
                    seen = 1; seen_addr = {mem_addr, mem_len};
                end else if ({mem_addr, mem_len} !== seen_addr) obs_unstable = 1;
                if (lat == 0) begin
                    n_acc++;
                    mem_ack = 1;
                    mem_zf = (n_acc <= 64) ? zf_seq[n_acc-1] : 1'b1;
                    if (n_acc >= irq_at) irq_pending = 1;
                    obs_q.push_back({mem_addr, mem_len});
                    seen = 0; lat = $urandom_range(0, 3);
                end else lat--;
            end else if ($urandom_range(0, 3) == 0) begin
                mem_ack = 1; mem_zf = 1'($urandom_range(0, 1));
            end
            if (!fin) begin
                @(negedge clk); obs_cycles++;
            end
        end
        obs_timeout = !fin;
        irq_pending = 0; mem_ack = 0;
        @(negedge clk);
        obs_extra = done | fault;
    endtask

    task automatic test_reset();
        set_defaults();
        rst = 1;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({busy, done, fault, mem_req} !== 4'b0) begin
            tests_failed++; $display("FAIL reset_ctrl: got %b expected 0000", {busy, done, fault, mem_req});
        end
        tests_run++;
        if (done_reason !== 2'd0 || mem_addr !== 32'h0 || mem_len !== 4'h0) begin
            tests_failed++; $display("FAIL reset_mem: got reason %0d addr %h len %0d expected 0 0 0", done_reason, mem_addr, mem_len);
        end
        tests_run++;
        if ({esi_out, edi_out, ecx_out} !== 96'h0) begin
            tests_failed++; $display("FAIL reset_regs: got %h %h %h expected zeros", esi_out, edi_out, ecx_out);
        end
        rst = 0;
        @(negedge clk);
    endtask

    task automatic test_count();
        set_defaults(); ecx_in = 3; edi_in = 32'h10;
        model_run(); run_op();
        tests_run++;
        if (obs_q.size() != 3 || exp_q.size() != 3) begin
            tests_failed++; $display("FAIL t1_nreq: got %0d expected 3 (model %0d)", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            tests_run++;
            if (obs_q[i] !== exp_q[i]) begin
                tests_failed++; $display("FAIL t1_access%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        tests_run++;
        if (!obs_done || obs_reason !== 2'd0 || obs_busy) begin
            tests_failed++; $display("FAIL t1_done: got done %0d reason %0d busy %0d expected 1 0 0", obs_done, obs_reason, obs_busy);
        end
        tests_run++;
        if (obs_edi !== 32'h13 || obs_ecx !== 32'h0 || obs_esi !== 32'h403) begin
            tests_failed++; $display("FAIL t1_regs: got edi %h ecx %h esi %h expected 13 0 403", obs_edi, obs_ecx, obs_esi);
        end
        tests_run++;
        if (obs_extra) begin
            tests_failed++; $display("FAIL t1_pulse: got done/fault still high expected low");
        end
    endtask

    task automatic test_ignored();
        set_defaults(); cfg_addr16 = 1; ecx_in = 32'hABCD_0000; edi_in = 32'h55;
        run_op();
        tests_run++;
        if (obs_q.size() != 0 || !obs_done || obs_reason !== 2'd3) begin
            tests_failed++; $display("FAIL t2_ignored: got nreq %0d done %0d reason %0d expected 0 1 3", obs_q.size(), obs_done, obs_reason);
        end
        tests_run++;
        if (obs_cycles != 2) begin
            tests_failed++; $display("FAIL t2_latency: got %0d expected 2", obs_cycles);
        end
        tests_run++;
        if (obs_ecx !== 32'hABCD_0000 || obs_edi !== 32'h55 || obs_esi !== 32'h400) begin
            tests_failed++; $display("FAIL t2_regs: got %h %h %h expected abcd0000 55 400", obs_ecx, obs_edi, obs_esi);
        end
    endtask

    task automatic test_addr16();
        set_defaults(); cfg_addr16 = 1; cfg_size = 1; cfg_dflag = 1;
        edi_in = 32'h1234_0000; ecx_in = 32'h0001_0002; esi_in = 32'h0005_0010; es_base = 32'h2000;
        model_run(); run_op();
        tests_run++;
        if (obs_q.size() != 2 || obs_q[0] !== {32'h2000, 4'd2} || obs_q[1] !== {32'h11FFE, 4'd2}) begin
            tests_failed++; $display("FAIL t3_access: got n %0d first %h expected 2 %h then %h", obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 36'h0, {32'h2000, 4'd2}, {32'h11FFE, 4'd2});
        end
        tests_run++;
        if (obs_edi !== 32'h1234_FFFC || obs_ecx !== 32'h0001_0000 || obs_esi !== 32'h0005_000C) begin
            tests_failed++; $display("FAIL t3_regs: got edi %h ecx %h esi %h expected 1234fffc 00010000 0005000c", obs_edi, obs_ecx, obs_esi);
        end
        tests_run++;
        if (obs_edi !== exp_edi || !obs_done || obs_reason !== exp_reason) begin
            tests_failed++; $display("FAIL t3_model: got edi %h reason %0d expected %h %0d", obs_edi, obs_reason, exp_edi, exp_reason);
        end
    endtask

    task automatic test_fault();
        set_defaults(); cfg_size = 2; cfg_rep = 0; edi_in = 32'hFFFE;
        run_op();
        tests_run++;
        if (!obs_fault || obs_done || obs_q.size() != 0 || obs_edi !== 32'hFFFE || obs_busy) begin
            tests_failed++; $display("FAIL t4_limit: got fault %0d done %0d nreq %0d edi %h expected 1 0 0 fffe", obs_fault, obs_done, obs_q.size(), obs_edi);
        end
        set_defaults(); cfg_rep = 0; es_cache = ES_OK | (64'h1 << 42); es_limit = 32'h0FFF; edi_in = 32'h0800;
        run_op();
        tests_run++;
        if (!obs_fault || obs_q.size() != 0) begin
            tests_failed++; $display("FAIL t4_expdown: got fault %0d nreq %0d expected 1 0", obs_fault, obs_q.size());
        end
        set_defaults(); cfg_rep = 0; cfg_size = 3; edi_in = 32'hFFF8;
        run_op();
        tests_run++;
        if (!obs_done || obs_q.size() != 1 || obs_edi !== 32'h10000 || (obs_q.size() == 1 && obs_q[0] !== {32'h10FF8, 4'd8})) begin
            tests_failed++; $display("FAIL t4_size8_ok: got done %0d nreq %0d edi %h expected 1 1 10000", obs_done, obs_q.size(), obs_edi);
        end
        set_defaults(); cfg_rep = 0; cfg_size = 3; edi_in = 32'hFFF9;
        run_op();
        tests_run++;
        if (!obs_fault || obs_q.size() != 0) begin
            tests_failed++; $display("FAIL t4_size8_fault: got fault %0d nreq %0d expected 1 0", obs_fault, obs_q.size());
        end
    endtask

    task automatic test_zf();
        set_defaults(); cfg_zf_cond = 1; ecx_in = 10; zf_seq[3] = 1'b0;
        model_run(); run_op();
        tests_run++;
        if (!obs_done || obs_reason !== 2'd1 || obs_ecx !== 32'd6 || obs_q.size() != 4) begin
            tests_failed++; $display("FAIL t5_zf: got done %0d reason %0d ecx %0d nreq %0d expected 1 1 6 4", obs_done, obs_reason, obs_ecx, obs_q.size());
        end
    endtask

    task automatic test_yield_irq();
        set_defaults(); ecx_in = 100;
        run_op();
        tests_run++;
        if (!obs_done || obs_reason !== 2'd2 || obs_ecx !== 32'd84 || obs_q.size() != 16) begin
            tests_failed++; $display("FAIL t6_yield: got reason %0d ecx %0d nreq %0d expected 2 84 16", obs_reason, obs_ecx, obs_q.size());
        end
        ecx_in = 84; edi_in = 32'h10;
        run_op();
        tests_run++;
        if (obs_reason !== 2'd2 || obs_ecx !== 32'd68) begin
            tests_failed++; $display("FAIL t6_yield_again: got reason %0d ecx %0d expected 2 68", obs_reason, obs_ecx);
        end
        set_defaults(); ecx_in = 100; irq_at = 2;
        run_op();
        tests_run++;
        if (!obs_done || obs_reason !== 2'd2 || obs_ecx !== 32'd98 || obs_edi !== 32'd2) begin
            tests_failed++; $display("FAIL t6_irq: got reason %0d ecx %0d edi %0d expected 2 98 2", obs_reason, obs_ecx, obs_edi);
        end
    endtask

    task automatic test_back_to_back();
        set_defaults(); ecx_in = 0;
        @(negedge clk); start = 1;
        @(negedge clk);
        @(negedge clk); start = 0;
        tests_run++;
        if (!done || busy || done_reason !== 2'd3) begin
            tests_failed++; $display("FAIL b2b_done: got done %0d busy %0d reason %0d expected 1 0 3", done, busy, done_reason);
        end
        @(negedge clk);
        tests_run++;
        if (busy || done) begin
            tests_failed++; $display("FAIL b2b_fin_start: got busy %0d done %0d expected 0 0", busy, done);
        end
        cfg_rep = 0; ecx_in = 7; edi_in = 32'h40;
        model_run(); run_op();
        tests_run++;
        if (!obs_done || obs_q.size() != 1 || obs_ecx !== 32'd6 || obs_q[0] !== exp_q[0]) begin
            tests_failed++; $display("FAIL b2b_single: got done %0d nreq %0d ecx %0d expected 1 1 6", obs_done, obs_q.size(), obs_ecx);
        end
    endtask

    task automatic test_random();
        logic [35:0] o, e;
        for (int n = 0; n < 40; n++) begin
            set_defaults();
            cfg_size = 2'($urandom_range(0, 3)); cfg_addr16 = 1'($urandom_range(0, 1));
            cfg_rep = 2'($urandom_range(0, 2)); cfg_zf_cond = 1'($urandom_range(0, 1));
            cfg_dflag = 1'($urandom_range(0, 1)); cfg_fault_check = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 2))
                0: es_limit = 32'hFFFF;
                1: es_limit = 32'hFFFF_FFFF;
                default: es_limit = $urandom_range(0, 32'hFFFF);
            endcase
            ecx_in = cfg_addr16 ? {16'($urandom), 16'($urandom_range(0, 20))} : $urandom_range(0, 20);
            edi_in = ($urandom_range(0, 1) == 1) ? es_limit - $urandom_range(0, 40) : $urandom_range(0, 32'hFFFF);
            if (cfg_addr16) edi_in[31:16] = 16'($urandom);
            esi_in = $urandom;
            es_base = $urandom;
            if ($urandom_range(0, 4) == 0) es_cache = ES_OK ^ (64'h1 << (41 + $urandom_range(0, 2)));
            if ($urandom_range(0, 4) == 0) es_cache[54] = 1'b0;
            es_cache_valid = ($urandom_range(0, 9) != 0);
            irq_at = $urandom_range(1, 25);
            for (int i = 0; i < 64; i++) zf_seq[i] = ($urandom_range(0, 5) != 0) ? (cfg_rep == 2) : (cfg_rep != 2);
            model_run(); run_op();
            tests_run++;
            if (obs_timeout || obs_fault !== (exp_kind == 1) || obs_done !== (exp_kind == 0)) begin
                tests_failed++; $display("FAIL rnd%0d_kind: got done %0d fault %0d timeout %0d expected kind %0d", n, obs_done, obs_fault, obs_timeout, exp_kind);
            end
            tests_run++;
            if (exp_kind == 0 && obs_reason !== exp_reason) begin
                tests_failed++; $display("FAIL rnd%0d_reason: got %0d expected %0d", n, obs_reason, exp_reason);
            end
            tests_run++;
            if (obs_q.size() != exp_q.size()) begin
                tests_failed++; $display("FAIL rnd%0d_nreq: got %0d expected %0d", n, obs_q.size(), exp_q.size());
            end
            for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
                o = obs_q[i]; e = exp_q[i];
                tests_run++;
                if (o !== e) begin
                    tests_failed++; $display("FAIL rnd%0d_access%0d: got %h expected %h", n, i, o, e);
                end
            end
            tests_run++;
            if (obs_esi !== exp_esi || obs_edi !== exp_edi || obs_ecx !== exp_ecx) begin
                tests_failed++; $display("FAIL rnd%0d_regs: got %h %h %h expected %h %h %h", n, obs_esi, obs_edi, obs_ecx, exp_esi, exp_edi, exp_ecx);
            end
            tests_run++;
            if (obs_unstable || obs_extra || obs_busy) begin
                tests_failed++; $display("FAIL rnd%0d_protocol: got unstable %0d extra %0d busy %0d expected 0 0 0", n, obs_unstable, obs_extra, obs_busy);
            end
        end
    endtask

    task automatic test_reset_mid_issue();
        int waited;
        set_defaults(); ecx_in = 100;
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        waited = 0;
        while (!mem_req && waited < 20) begin
            @(negedge clk); waited++;
        end
        tests_run++;
        if (!mem_req) begin
            tests_failed++; $display("FAIL rst_issue_req: got mem_req 0 expected 1 within 20 cycles");
        end
        rst = 1;
        #1;
        tests_run++;
        if (mem_req !== 1'b0 || busy !== 1'b0 || ecx_out !== 32'h0) begin
            tests_failed++; $display("FAIL rst_issue_drop: got req %0d busy %0d ecx %h expected 0 0 0", mem_req, busy, ecx_out);
        end
        @(negedge clk); rst = 0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_count();
        test_ignored();
        test_addr16();
        test_fault();
        test_zf();
        test_yield_irq();
        test_back_to_back();
        test_random();
        test_reset_mid_issue();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
